dmem_responder: RTL and testbench

//   Data-memory responder for the RISC-V core's load/store port. Accepts one

---
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a valid/ready request port and a response
// returned after LATENCY programmable wait states; byte-lane write strobes.
module dmem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = i;
        end
        return m;
    endfunction

    // Power-up image mem[i] = i; reset deliberately leaves contents alone.
    mem_t mem = mem_init();

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        accept;
    logic        commit;

    logic        req_write_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;

    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_err;
    logic [AW-1:0] c_word;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // With zero wait states the commit edge is the acceptance edge, so the
    // live request fields are used instead of the registered copy.
    always_comb begin
        if (state == IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_write = req_write_q;
            c_addr  = req_addr_q;
            c_wdata = req_wdata_q;
            c_wstrb = req_wstrb_q;
        end
        c_err  = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
        c_word = c_addr[AW+1:2];
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                    commit   = !rst;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                req_write_q <= req_write;
                req_addr_q  <= req_addr;
                req_wdata_q <= req_wdata;
                req_wstrb_q <= req_wstrb;
            end
            if (commit) begin
                resp_err   <= c_err;
                resp_rdata <= (c_write || c_err) ? '0 : mem[c_word];
            end else if ((state == RESP) && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_write && !c_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (c_wstrb[b]) begin
                    mem[c_word][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0
// instance, each with its own private memory.
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        z_rst, z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic [3:0]  z_req_wstrb;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(128), .LATENCY(0)) dut_z (
        .clk(clk), .rst(z_rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_wstrb(z_req_wstrb), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; n counts edges from the acceptance edge
    // (inclusive) to the edge where resp_valid is first seen.
    task automatic txn(input bit z, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int n, output logic [31:0] rd, output logic er);
        if (z) begin
            z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_wstrb = s;
            z_resp_ready = 1'b0;
        end else begin
            req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
            resp_ready = 1'b0;
        end
        tick();
        n = 1;
        req_valid = 1'b0;
        z_req_valid = 1'b0;
        while (!(z ? z_resp_valid : resp_valid) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!(z ? z_resp_valid : resp_valid)) begin
            errors++;
            $display("FAIL txn_timeout addr=%h: no resp_valid within %0d edges, required within 16", a, n);
        end
        rd = z ? z_resp_rdata : resp_rdata;
        er = z ? z_resp_err : resp_err;
        if (z) z_resp_ready = 1'b1; else resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        z_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; resp_ready = 1'b0;
        z_rst = 1'b1; z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
        z_req_wstrb = '0; z_resp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++;
        if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata); end
        checks++;
        if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
        rst = 1'b0;
        z_rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_latency();
        int n; logic [31:0] rd; logic er;
        txn(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL load_latency: got %0d edges expected 3", n); end
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL load_0x14_rdata: got %h expected 00000005", rd); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL load_0x14_err: got %b expected 0", er); end
    endtask

    task automatic test_store_strobe();
        int n; logic [31:0] rd; logic er;
        txn(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'b0011, n, rd, er);
        checks++;
        if (n !== 3 || rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL store_resp: got n=%0d rdata=%h err=%b expected n=3 rdata=0 err=0", n, rd, er);
        end
        txn(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL strobe_lo: got %h expected 0000beef", rd); end
        txn(1'b0, 1'b1, 32'h1C, 32'h12345678, 4'b1100, n, rd, er);
        txn(1'b0, 1'b0, 32'h1C, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h12340007) begin errors++; $display("FAIL strobe_hi: got %h expected 12340007", rd); end
        txn(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, n, rd, er);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL zero_strobe_err: got %b expected 0", er); end
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL zero_strobe_mem: got %h expected 00000004", rd); end
    endtask

    task automatic test_errors();
        int n; logic [31:0] rd; logic er;
        txn(1'b0, 1'b0, 32'h06, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || n !== 3) begin
            errors++; $display("FAIL misaligned_load: got err=%b rdata=%h n=%0d expected err=1 rdata=0 n=3", er, rd, n);
        end
        txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL range_load: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
        end
        txn(1'b0, 1'b0, 32'h1FC, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'd127) begin
            errors++; $display("FAIL last_word: got err=%b rdata=%h expected err=0 rdata=0000007f", er, rd);
        end
        txn(1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, n, rd, er);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL range_store_err: got %b expected 1", er); end
        txn(1'b0, 1'b1, 32'h07, 32'hFFFFFFFF, 4'hF, n, rd, er);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL misaligned_store_err: got %b expected 1", er); end
        txn(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL range_store_nowrite: got %h expected 00000000", rd); end
        txn(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL misaligned_store_nowrite: got %h expected 00000001", rd); end
    endtask

    task automatic test_backpressure();
        int n; logic [31:0] rd; logic er;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h18; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        tick();
        // Garbage store held on the bus while busy must be ignored.
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_req_ready: got %b expected 0", req_ready); end
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL bp_latency: got %0d extra edges expected 2", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h6 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b expected 1 00000006 0 0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b rdata=%h expected 0 1 00000000",
                     resp_valid, req_ready, resp_rdata);
        end
        req_valid = 1'b0;
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h8) begin errors++; $display("FAIL ignored_store: got %h expected 00000008", rd); end
    endtask

    task automatic test_reset_mid();
        int n; logic [31:0] rd; logic er;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0C; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL wait_reset: got valid=%b rdata=%h err=%b ready=%b expected 0 0 0 0",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL wait_reset_idle: got valid=%b ready=%b expected 0 1", resp_valid, req_ready);
        end
        txn(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL aborted_store: got %h expected 00000003", rd); end

        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14;
        for (int i = 0; i < 3; i++) begin tick(); req_valid = 1'b0; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL resp_reset: got valid=%b rdata=%h expected 0 00000000", resp_valid, resp_rdata);
        end

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0C;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_vs_accept[%0d]: got valid=%b expected 0", i, resp_valid); end
            tick();
        end
        txn(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL rst_vs_accept_mem: got %h expected 00000003", rd); end
    endtask

    task automatic test_zero_latency();
        int n; logic [31:0] rd; logic er;
        txn(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (n !== 1 || rd !== 32'h1 || er !== 1'b0) begin
            errors++; $display("FAIL lat0_load: got n=%0d rdata=%h err=%b expected n=1 rdata=00000001 err=0", n, rd, er);
        end
        txn(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, n, rd, er);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, n, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL lat0_store: got %h expected cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        z_req_valid = 1'b1; z_req_write = 1'b0; z_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            z_req_addr = 32'(k * 4);
            checks++;
            if (z_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, z_req_ready); end
            tick();
            checks++;
            if (z_resp_valid !== 1'b1 || z_resp_rdata !== 32'(k) || z_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_resp[%0d]: got valid=%b rdata=%h ready=%b expected 1 %h 0",
                         k, z_resp_valid, z_resp_rdata, z_req_ready, 32'(k));
            end
            tick();
            checks++;
            if (z_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 0", k, z_resp_valid); end
        end
        z_req_valid = 1'b0; z_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_latency();
        test_store_strobe();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_zero_latency();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
